// File: rtl/axil_reg_slave_pkg.sv
// Shared response codes, data widths and the address decode helper
// for the AXI4-Lite register slave.
package axil_reg_slave_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam int         REG_W           = 32;
   localparam int         STRB_W          = REG_W / 8;

   typedef struct packed {
      logic        inRange;
      logic [31:0] offset;
   } decode_t;

   // Subtracting the base first makes addresses below the window wrap high and land out of range.
   function automatic decode_t decodeAddr(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int          nReg);
      decode_t d;
      d.offset  = addr - base;
      d.inRange = (d.offset < 32'(4 * nReg));
      return d;
   endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave holding NREG 32-bit registers, with independent AW/W capture,
// byte strobes, OKAY/SLVERR responses and a one-cycle write-notify strobe.
module axil_reg_slave
   import axil_reg_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          NREG      = 16,
   localparam int         IDX_W     = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           s_axi_awaddr,
   input  logic [2:0]            s_axi_awprot,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [STRB_W-1:0]     s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [31:0]           s_axi_araddr,
   input  logic [2:0]            s_axi_arprot,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [32*NREG-1:0]    reg_q_o,
   output logic                  wr_pulse_o,
   output logic [IDX_W-1:0]      wr_idx_o
);

   logic              r_awHeld;
   logic              r_wHeld;
   logic [31:0]       r_awAddr;
   logic [31:0]       r_wData;
   logic [STRB_W-1:0] r_wStrb;
   logic              r_bvalid;
   logic [1:0]        r_bresp;
   logic              r_wrPulse;
   logic [IDX_W-1:0]  r_wrIdx;
   logic              r_rvalid;
   logic [31:0]       r_rdata;
   logic [1:0]        r_rresp;
   logic [REG_W-1:0]  r_regs [NREG];

   logic              w_awReady;
   logic              w_wReady;
   logic              w_arReady;
   logic              w_awHs;
   logic              w_wHs;
   logic              w_arHs;
   logic              w_commit;
   logic [31:0]       w_wrAddr;
   logic [31:0]       w_wrData;
   logic [STRB_W-1:0] w_wrStrb;
   decode_t           w_wrDec;
   decode_t           w_rdDec;
   logic [IDX_W-1:0]  w_wrIdx;
   logic [IDX_W-1:0]  w_rdIdx;
   logic              w_unusedBits;

   assign w_awReady = !r_awHeld && !r_bvalid;
   assign w_wReady  = !r_wHeld && !r_bvalid;
   assign w_arReady = !r_rvalid;
   assign w_awHs    = s_axi_awvalid && w_awReady;
   assign w_wHs     = s_axi_wvalid && w_wReady;
   assign w_arHs    = s_axi_arvalid && w_arReady;

   // A channel counts as available when already held or handshaking on this very edge.
   assign w_commit  = (r_awHeld || w_awHs) && (r_wHeld || w_wHs) && !r_bvalid;
   assign w_wrAddr  = r_awHeld ? r_awAddr : s_axi_awaddr;
   assign w_wrData  = r_wHeld ? r_wData : s_axi_wdata;
   assign w_wrStrb  = r_wHeld ? r_wStrb : s_axi_wstrb;

   assign w_wrDec   = decodeAddr(w_wrAddr, BASE_ADDR, NREG);
   assign w_rdDec   = decodeAddr(s_axi_araddr, BASE_ADDR, NREG);
   assign w_wrIdx   = w_wrDec.offset[IDX_W+1:2];
   assign w_rdIdx   = w_rdDec.offset[IDX_W+1:2];

   assign w_unusedBits = ^{s_axi_awprot, s_axi_arprot, w_wrDec.offset, w_rdDec.offset};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_awHeld  <= 1'b0;
         r_wHeld   <= 1'b0;
         r_awAddr  <= '0;
         r_wData   <= '0;
         r_wStrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= AXI_RESP_OKAY;
         r_wrPulse <= 1'b0;
         r_wrIdx   <= '0;
      end else begin
         r_wrPulse <= w_commit && w_wrDec.inRange;
         if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wrDec.inRange ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            if (w_wrDec.inRange) begin
               r_wrIdx <= w_wrIdx;
            end
         end else begin
            if (w_awHs) begin
               r_awHeld <= 1'b1;
               r_awAddr <= s_axi_awaddr;
            end
            if (w_wHs) begin
               r_wHeld <= 1'b1;
               r_wData <= s_axi_wdata;
               r_wStrb <= s_axi_wstrb;
            end
            if (r_bvalid && s_axi_bready) begin
               r_bvalid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit && w_wrDec.inRange) begin
         for (int j = 0; j < STRB_W; j++) begin
            if (w_wrStrb[j]) begin
               r_regs[w_wrIdx][8*j +: 8] <= w_wrData[8*j +: 8];
            end
         end
      end
   end

   // Reads sample the array before any same-edge write lands, so they return the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= AXI_RESP_OKAY;
      end else if (w_arHs) begin
         r_rvalid <= 1'b1;
         if (w_rdDec.inRange) begin
            r_rdata <= r_regs[w_rdIdx];
            r_rresp <= AXI_RESP_OKAY;
         end else begin
            r_rdata <= '0;
            r_rresp <= AXI_RESP_SLVERR;
         end
      end else if (r_rvalid && s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : gRegOut
      assign reg_q_o[32*g +: 32] = r_regs[g];
   end

   assign s_axi_awready = w_awReady;
   assign s_axi_wready  = w_wReady;
   assign s_axi_arready = w_arReady;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign wr_pulse_o    = r_wrPulse;
   assign wr_idx_o      = r_wrIdx;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: a table of write/readback vectors plus hand-built
// sequences for split AW/W, back-pressure, same-edge read/write and mid-transaction reset.
module tb_axil_reg_slave;
   import axil_reg_slave_pkg::*;

   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam int          NREG  = 16;
   localparam int          IDX_W = $clog2(NREG);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [31:0]         awAddr = '0;
   logic [2:0]          awProt = '0;
   logic                awValid = 1'b0;
   logic                awReady;
   logic [31:0]         wData = '0;
   logic [3:0]          wStrb = '0;
   logic                wValid = 1'b0;
   logic                wReady;
   logic [1:0]          bResp;
   logic                bValid;
   logic                bReady = 1'b1;
   logic [31:0]         arAddr = '0;
   logic [2:0]          arProt = '0;
   logic                arValid = 1'b0;
   logic                arReady;
   logic [31:0]         rData;
   logic [1:0]          rResp;
   logic                rValid;
   logic                rReady = 1'b1;
   logic [32*NREG-1:0]  regQ;
   logic                wrPulse;
   logic [IDX_W-1:0]    wrIdx;

   always #5 clk = ~clk;

   axil_reg_slave #(.BASE_ADDR(BASE), .NREG(NREG)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(awAddr), .s_axi_awprot(awProt), .s_axi_awvalid(awValid), .s_axi_awready(awReady),
      .s_axi_wdata(wData), .s_axi_wstrb(wStrb), .s_axi_wvalid(wValid), .s_axi_wready(wReady),
      .s_axi_bresp(bResp), .s_axi_bvalid(bValid), .s_axi_bready(bReady),
      .s_axi_araddr(arAddr), .s_axi_arprot(arProt), .s_axi_arvalid(arValid), .s_axi_arready(arReady),
      .s_axi_rdata(rData), .s_axi_rresp(rResp), .s_axi_rvalid(rValid), .s_axi_rready(rReady),
      .reg_q_o(regQ), .wr_pulse_o(wrPulse), .wr_idx_o(wrIdx)
   );

   typedef struct {
      logic [1:0]       resp;
      logic             pulse;
      logic [IDX_W-1:0] idx;
   } BExp_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } RExp_t;

   typedef struct {
      logic [31:0]      addr;
      logic [31:0]      data;
      logic [3:0]       strb;
      logic [1:0]       expResp;
      logic [IDX_W-1:0] expIdx;
      logic [31:0]      expRead;
   } Vec_t;

   BExp_t bQ[$];
   RExp_t rQ[$];
   Vec_t  vecs[8];
   int    checks = 0;
   int    errors = 0;

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectB(input logic [1:0] resp, input logic pulse, input logic [IDX_W-1:0] idx);
      BExp_t e;
      e.resp  = resp;
      e.pulse = pulse;
      e.idx   = idx;
      bQ.push_back(e);
   endtask

   task automatic expectR(input logic [1:0] resp, input logic [31:0] data);
      RExp_t e;
      e.resp = resp;
      e.data = data;
      rQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string name);
      bit awDone = 1'b0;
      bit wDone  = 1'b0;
      int n      = 0;
      awAddr  = a;
      wData   = d;
      wStrb   = s;
      awValid = 1'b1;
      wValid  = 1'b1;
      while (!(awDone && wDone) && n < 20) begin
         if (awValid && awReady) awDone = 1'b1;
         if (wValid && wReady) wDone = 1'b1;
         tick();
         n++;
         if (awDone) awValid = 1'b0;
         if (wDone) wValid = 1'b0;
      end
      awValid = 1'b0;
      wValid  = 1'b0;
      if (!(awDone && wDone)) checkOutput({name, " write accept timeout"}, 0, 1);
   endtask

   task automatic driveRead(input logic [31:0] a, input string name);
      bit done = 1'b0;
      int n    = 0;
      arAddr  = a;
      arValid = 1'b1;
      while (!done && n < 20) begin
         if (arReady) done = 1'b1;
         tick();
         n++;
      end
      arValid = 1'b0;
      if (!done) checkOutput({name, " read accept timeout"}, 0, 1);
   endtask

   task automatic collectB(input string name);
      BExp_t e;
      int n = 0;
      while (!bValid && n < 20) begin
         tick();
         n++;
      end
      if (!bValid) begin
         checkOutput({name, " bvalid timeout"}, 0, 1);
         return;
      end
      if (bQ.size() == 0) begin
         checkOutput({name, " unexpected B response"}, 1, 0);
         return;
      end
      e = bQ.pop_front();
      checkOutput({name, " bresp"}, bResp, e.resp);
      checkOutput({name, " wr_pulse"}, wrPulse, e.pulse);
      if (e.pulse) checkOutput({name, " wr_idx"}, wrIdx, e.idx);
      bReady = 1'b1;
      tick();
      checkOutput({name, " bvalid drop"}, bValid, 0);
   endtask

   task automatic collectR(input string name);
      RExp_t e;
      int n = 0;
      while (!rValid && n < 20) begin
         tick();
         n++;
      end
      if (!rValid) begin
         checkOutput({name, " rvalid timeout"}, 0, 1);
         return;
      end
      if (rQ.size() == 0) begin
         checkOutput({name, " unexpected R response"}, 1, 0);
         return;
      end
      e = rQ.pop_front();
      checkOutput({name, " rdata"}, rData, e.data);
      checkOutput({name, " rresp"}, rResp, e.resp);
      rReady = 1'b1;
      tick();
      checkOutput({name, " rvalid drop"}, rValid, 0);
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, " awready"}, awReady, 1);
      checkOutput({name, " wready"}, wReady, 1);
      checkOutput({name, " arready"}, arReady, 1);
      checkOutput({name, " bvalid"}, bValid, 0);
      checkOutput({name, " rvalid"}, rValid, 0);
      checkOutput({name, " bresp"}, bResp, 0);
      checkOutput({name, " rresp"}, rResp, 0);
      checkOutput({name, " rdata"}, rData, 0);
      checkOutput({name, " wr_pulse"}, wrPulse, 0);
      checkOutput({name, " wr_idx"}, wrIdx, 0);
      checkOutput({name, " reg_q"}, regQ, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [32*NREG-1:0] expFlat;

      // addr, data, strb, expected bresp/rresp, expected wr_idx, expected readback
      vecs[0] = '{BASE + 32'h08,  32'hDEAD_BEEF, 4'hF,    AXI_RESP_OKAY,   IDX_W'(2),  32'hDEAD_BEEF};
      vecs[1] = '{BASE + 32'h3C,  32'h1234_5678, 4'hF,    AXI_RESP_OKAY,   IDX_W'(15), 32'h1234_5678};
      vecs[2] = '{BASE + 32'h40,  32'hFFFF_FFFF, 4'hF,    AXI_RESP_SLVERR, IDX_W'(0),  32'h0000_0000};
      vecs[3] = '{BASE - 32'h04,  32'hAAAA_AAAA, 4'hF,    AXI_RESP_SLVERR, IDX_W'(0),  32'h0000_0000};
      vecs[4] = '{BASE + 32'h0B,  32'h0000_0011, 4'b0001, AXI_RESP_OKAY,   IDX_W'(2),  32'hDEAD_BE11};
      vecs[5] = '{BASE + 32'h3C,  32'hFFFF_FFFF, 4'b0000, AXI_RESP_OKAY,   IDX_W'(15), 32'h1234_5678};
      vecs[6] = '{BASE + 32'h00,  32'hCAFE_F00D, 4'b1100, AXI_RESP_OKAY,   IDX_W'(0),  32'hCAFE_0000};
      vecs[7] = '{BASE + 32'h3C,  32'hA5A5_A5A5, 4'b1010, AXI_RESP_OKAY,   IDX_W'(15), 32'hA534_A578};

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkResetState("init");

      for (int i = 0; i < 8; i++) begin
         expectB(vecs[i].expResp, vecs[i].expResp == AXI_RESP_OKAY, vecs[i].expIdx);
         bReady = 1'b1;
         applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].strb, $sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d bvalid latency", i), bValid, 1);
         collectB($sformatf("vec%0d", i));
         expectR(vecs[i].expResp, vecs[i].expRead);
         driveRead(vecs[i].addr, $sformatf("vec%0d", i));
         collectR($sformatf("vec%0d read", i));
      end

      expFlat          = '0;
      expFlat[0+:32]   = 32'hCAFE_0000;
      expFlat[64+:32]  = 32'hDEAD_BE11;
      expFlat[480+:32] = 32'hA534_A578;
      checkOutput("regfile after table", regQ, expFlat);

      // W three cycles ahead of AW; commit lands on the AW edge
      expectB(AXI_RESP_OKAY, 1'b1, IDX_W'(1));
      bReady = 1'b1;
      wData  = 32'h1122_3344;
      wStrb  = 4'b0101;
      wValid = 1'b1;
      tick();
      wValid = 1'b0;
      checkOutput("split wready held", wReady, 0);
      checkOutput("split awready free", awReady, 1);
      tick();
      tick();
      checkOutput("split no early bvalid", bValid, 0);
      awAddr  = BASE + 32'h04;
      awValid = 1'b1;
      tick();
      awValid = 1'b0;
      checkOutput("split bvalid on AW edge", bValid, 1);
      collectB("split");
      expectR(AXI_RESP_OKAY, 32'h0022_0044);
      driveRead(BASE + 32'h04, "split");
      collectR("split read");

      // B back-pressure blocks a second write until the B handshake
      bReady = 1'b0;
      applyStimulus(BASE + 32'h10, 32'h0000_0077, 4'hF, "bp first");
      checkOutput("bp first wr_pulse", wrPulse, 1);
      checkOutput("bp first wr_idx", wrIdx, 4);
      awAddr  = BASE + 32'h14;
      wData   = 32'h0000_0055;
      wStrb   = 4'hF;
      awValid = 1'b1;
      wValid  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp bvalid hold %0d", c), bValid, 1);
         checkOutput($sformatf("bp bresp hold %0d", c), bResp, AXI_RESP_OKAY);
         checkOutput($sformatf("bp awready low %0d", c), awReady, 0);
         checkOutput($sformatf("bp wready low %0d", c), wReady, 0);
         tick();
      end
      expectB(AXI_RESP_OKAY, 1'b0, IDX_W'(4));
      collectB("bp first");
      checkOutput("bp awready back", awReady, 1);
      checkOutput("bp wready back", wReady, 1);
      expectB(AXI_RESP_OKAY, 1'b1, IDX_W'(5));
      tick();
      awValid = 1'b0;
      wValid  = 1'b0;
      checkOutput("bp second bvalid", bValid, 1);
      collectB("bp second");
      expectR(AXI_RESP_OKAY, 32'h0000_0077);
      driveRead(BASE + 32'h10, "bp reg4");
      collectR("bp reg4 read");
      expectR(AXI_RESP_OKAY, 32'h0000_0055);
      driveRead(BASE + 32'h14, "bp reg5");
      collectR("bp reg5 read");

      // Same-edge read and write of reg3, then R back-pressure
      expectB(AXI_RESP_OKAY, 1'b1, IDX_W'(3));
      applyStimulus(BASE + 32'h0C, 32'd5, 4'hF, "rw seed");
      collectB("rw seed");
      rReady = 1'b0;
      bReady = 1'b1;
      expectB(AXI_RESP_OKAY, 1'b1, IDX_W'(3));
      expectR(AXI_RESP_OKAY, 32'd5);
      awAddr  = BASE + 32'h0C;
      wData   = 32'd9;
      wStrb   = 4'hF;
      arAddr  = BASE + 32'h0C;
      awValid = 1'b1;
      wValid  = 1'b1;
      arValid = 1'b1;
      tick();
      awValid = 1'b0;
      wValid  = 1'b0;
      arValid = 1'b0;
      checkOutput("rw reg3 committed", regQ[96+:32], 32'd9);
      collectB("rw write");
      for (int c = 0; c < 4; c++) begin
         checkOutput($sformatf("rw rvalid hold %0d", c), rValid, 1);
         checkOutput($sformatf("rw rdata hold %0d", c), rData, 32'd5);
         checkOutput($sformatf("rw arready low %0d", c), arReady, 0);
         tick();
      end
      collectR("rw old value");
      expectR(AXI_RESP_OKAY, 32'd9);
      driveRead(BASE + 32'h0C, "rw new");
      collectR("rw new value");

      // Reset with an AW held and read data pending
      awAddr  = BASE + 32'h18;
      awValid = 1'b1;
      tick();
      awValid = 1'b0;
      checkOutput("rst aw held", awReady, 0);
      arAddr  = BASE + 32'h0C;
      arValid = 1'b1;
      rReady  = 1'b0;
      tick();
      arValid = 1'b0;
      checkOutput("rst rvalid pending", rValid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkResetState("midreset");
      wData  = 32'h0000_0001;
      wStrb  = 4'hF;
      wValid = 1'b1;
      bReady = 1'b1;
      tick();
      wValid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checkOutput($sformatf("midreset no stray bvalid %0d", c), bValid, 0);
         tick();
      end
      checkOutput("midreset regs stay clear", regQ, 0);

      checkOutput("scoreboard B drained", bQ.size(), 0);
      checkOutput("scoreboard R drained", rQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
